// File: rtl/cpu_controller_mc.sv
// cpu_controller_mc: FETCH/DECODE/EXEC sequencer for the 8-bit RISC CPU.
// Define CTRL_PERF_CNT_EN to add the 32-bit retired-instruction counter.
module cpu_controller_mc #(
  parameter int OPCODE_W = 3,
  parameter int MEM_WAIT = 0,
  parameter int WAIT_W   = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                Load_in,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                Zero,
  output logic                mem_rd,
  output logic                ir_load,
  output logic                pc_inc,
  output logic                pc_load,
  output logic                En_acc,
  output logic                En_mem,
  output logic                En_run,
  output logic [OPCODE_W-1:0] ALU_OP,
  output logic                halted,
  output logic                illegal_op,
  output logic [2:0]          state
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0]         retired
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [2:0] OP_HALT = 3'b000;
  localparam logic [2:0] OP_SKZ  = 3'b001;
  localparam logic [2:0] OP_STO  = 3'b110;
  localparam logic [2:0] OP_JMP  = 3'b111;
  localparam logic [WAIT_W-1:0] LAST = WAIT_W'(MEM_WAIT);

  state_t            st;
  logic [WAIT_W-1:0] cnt;
  logic [2:0]        cls;
  logic              done;
  logic              op_ill;
  logic              dec_halt;
  logic              dec_skz;
  logic              dec_jmp;
  logic              dec_exec;
  logic              ex_sto;

  assign done     = cnt == LAST;
  assign cls      = Opcode[2:0];
  // Any set bit above the class field makes the opcode illegal.
  assign op_ill   = (Opcode >> 3) != '0;
  assign dec_halt = !op_ill && cls == OP_HALT;
  assign dec_skz  = !op_ill && cls == OP_SKZ;
  assign dec_jmp  = !op_ill && cls == OP_JMP;
  assign dec_exec = !op_ill && cls inside {[3'b010:3'b110]};
  assign ex_sto   = ALU_OP[2:0] == OP_STO;

  assign state  = st;
  assign halted = st == S_HALT;
  assign En_run = st inside {S_FETCH, S_DECODE, S_EXEC};

  always_comb begin
    mem_rd     = 1'b0;
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    En_acc     = 1'b0;
    En_mem     = 1'b0;
    illegal_op = 1'b0;
    unique case (1'b1)
      st == S_FETCH: begin
        mem_rd  = 1'b1;
        ir_load = done;
        pc_inc  = done;
      end
      st == S_DECODE: begin
        illegal_op = op_ill;
        pc_inc     = dec_skz && Zero;
        pc_load    = dec_jmp;
      end
      st == S_EXEC: begin
        mem_rd = !ex_sto;
        En_acc = done && !ex_sto;
        En_mem = done && ex_sto;
      end
      default: ;
    endcase
    if (Load_in) begin
      mem_rd     = 1'b0;
      ir_load    = 1'b0;
      pc_inc     = 1'b0;
      pc_load    = 1'b0;
      En_acc     = 1'b0;
      En_mem     = 1'b0;
      illegal_op = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      st     <= S_IDLE;
      cnt    <= '0;
      ALU_OP <= '0;
    end else if (Load_in) begin
      st  <= S_IDLE;
      cnt <= '0;
    end else begin
      case (st)
        S_IDLE: st <= S_FETCH;
        S_FETCH, S_EXEC: begin
          if (done) begin
            cnt <= '0;
            st  <= (st == S_FETCH) ? S_DECODE : S_FETCH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DECODE: begin
          ALU_OP <= Opcode;
          if (dec_halt)
            st <= S_HALT;
          else if (dec_exec)
            st <= S_EXEC;
          else
            st <= S_FETCH;
        end
        S_HALT: st <= S_HALT;
        default: begin
          st  <= S_IDLE;
          cnt <= '0;
        end
      endcase
    end
  end

`ifdef CTRL_PERF_CNT_EN
  logic retire;

  // Aborted instructions (Load_in) never count as retired.
  assign retire = !Load_in &&
    ((st == S_DECODE && (op_ill || dec_skz || dec_jmp)) ||
     (st == S_EXEC && done));

  always_ff @(posedge clock) begin
    if (!reset_n)
      retired <= '0;
    else if (retire)
      retired <= retired + 32'd1;
  end
`endif

endmodule

// File: tb/tb_cpu_controller_mc.sv
// tb_cpu_controller_mc: vector table on a 3-bit/no-wait controller plus
// random instruction streams on a 4-bit/two-wait controller.
module tb_cpu_controller_mc;

  localparam int MW = 2;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  logic       rst_a, ld_a, z_a;
  logic [2:0] op_a, alu_a, st_a;
  logic       mr_a, irl_a, pci_a, pcl_a, ea_a, em_a;
  logic       run_a, hlt_a, ill_a;

  logic       rst_b, ld_b, z_b;
  logic [3:0] op_b, alu_b;
  logic [2:0] st_b;
  logic       mr_b, irl_b, pci_b, pcl_b, ea_b, em_b;
  logic       run_b, hlt_b, ill_b;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] ret_a, ret_b;
`endif

  cpu_controller_mc #(.OPCODE_W(3), .MEM_WAIT(0), .WAIT_W(4)) u_a (
    .clock(clock), .reset_n(rst_a), .Load_in(ld_a),
    .Opcode(op_a), .Zero(z_a),
    .mem_rd(mr_a), .ir_load(irl_a), .pc_inc(pci_a),
    .pc_load(pcl_a), .En_acc(ea_a), .En_mem(em_a),
    .En_run(run_a), .ALU_OP(alu_a), .halted(hlt_a),
    .illegal_op(ill_a), .state(st_a)
`ifdef CTRL_PERF_CNT_EN
    , .retired(ret_a)
`endif
  );

  cpu_controller_mc #(.OPCODE_W(4), .MEM_WAIT(MW), .WAIT_W(2)) u_b (
    .clock(clock), .reset_n(rst_b), .Load_in(ld_b),
    .Opcode(op_b), .Zero(z_b),
    .mem_rd(mr_b), .ir_load(irl_b), .pc_inc(pci_b),
    .pc_load(pcl_b), .En_acc(ea_b), .En_mem(em_b),
    .En_run(run_b), .ALU_OP(alu_b), .halted(hlt_b),
    .illegal_op(ill_b), .state(st_b)
`ifdef CTRL_PERF_CNT_EN
    , .retired(ret_b)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // stb = {mem_rd, ir_load, pc_inc, pc_load, En_acc, En_mem}
  typedef struct {
    logic       rst;
    logic       ld;
    logic [2:0] op;
    logic       z;
    logic [2:0] st;
    logic [5:0] stb;
    logic       ill;
    logic       hlt;
    logic [2:0] alu;
  } vec_t;

  function automatic vec_t mk(logic rst, logic ld, logic [2:0] op,
                              logic z, logic [2:0] st, logic [5:0] stb,
                              logic hlt, logic [2:0] alu);
    vec_t v;
    v.rst = rst; v.ld = ld; v.op = op; v.z = z;
    v.st = st; v.stb = stb; v.ill = 1'b0; v.hlt = hlt; v.alu = alu;
    return v;
  endfunction

  typedef struct packed {
    logic [2:0] st;
    logic [5:0] stb;
    logic       ill;
    logic       ret;
  } exp_t;

  logic [3:0]  m_alu;
  int unsigned m_ret;

  task automatic cyc_b(input logic ld, input logic [3:0] op,
                       input logic z, input logic [2:0] est,
                       input logic [5:0] estb, input logic eill,
                       input string tag);
    ld_b = ld; op_b = op; z_b = z;
    @(negedge clock);
    chk({tag, " state"}, 32'(st_b), 32'(est));
    chk({tag, " strobes"},
        32'({mr_b, irl_b, pci_b, pcl_b, ea_b, em_b}),
        32'(ld ? 6'b0 : estb));
    chk({tag, " illegal_op"}, 32'(ill_b), 32'(eill && !ld));
    chk({tag, " halted"}, 32'(hlt_b), 32'(est == 3'd4));
    chk({tag, " En_run"}, 32'(run_b), 32'(est inside {[3'd1:3'd3]}));
    chk({tag, " ALU_OP"}, 32'(alu_b), 32'(m_alu));
`ifdef CTRL_PERF_CNT_EN
    chk({tag, " retired"}, ret_b, m_ret);
`endif
    @(posedge clock);
    #1;
  endtask

  // Expected per-cycle trace of one instruction, from the latency rules.
  task automatic run_instr(input logic [3:0] op, input logic z,
                           input int abort, input int nh);
    exp_t       q[$];
    logic       legal, last, sto, ab;
    logic [2:0] c;
    string      tag;
    legal = !op[3];
    c     = op[2:0];
    sto   = c == 3'b110;
    ab    = 1'b0;
    tag   = $sformatf("op%0h", op);
    for (int k = 0; k <= MW; k++) begin
      last = k == MW;
      q.push_back({3'd1, 1'b1, last, last, 3'b000, 1'b0, 1'b0});
    end
    q.push_back({3'd2, 2'b00, legal && c == 3'd1 && z,
                 legal && c == 3'd7, 2'b00, !legal,
                 !legal || c == 3'd1 || c == 3'd7});
    if (legal && c inside {[3'd2:3'd6]})
      for (int k = 0; k <= MW; k++) begin
        last = k == MW;
        q.push_back({3'd3, !sto, 3'b000, last && !sto,
                     last && sto, 1'b0, last});
      end
    foreach (q[i]) begin
      logic ld;
      ld = i == abort;
      cyc_b(ld, q[i].st == 3'd3 ? 4'($urandom) : op,
            q[i].st == 3'd2 ? z : 1'($urandom),
            q[i].st, q[i].stb, q[i].ill, tag);
      if (ld) begin
        ab = 1'b1;
        break;
      end
      if (q[i].st == 3'd2) m_alu = op;
      if (q[i].ret) m_ret++;
    end
    if (ab) begin
      cyc_b(1'b0, 4'($urandom), 1'($urandom), 3'd0, 6'b0, 1'b0,
            "idle after load");
    end else if (legal && c == 3'd0) begin
      for (int k = 0; k < nh; k++)
        cyc_b(1'b0, 4'($urandom), 1'($urandom), 3'd4, 6'b0, 1'b0,
              "halt hold");
      cyc_b(1'b1, 4'($urandom), 1'($urandom), 3'd4, 6'b0, 1'b0,
            "halt load");
      cyc_b(1'b0, 4'($urandom), 1'($urandom), 3'd0, 6'b0, 1'b0,
            "halt idle");
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    logic [3:0] op;

    tbl.push_back(mk(0, 0, 2, 0, 0, 6'b000000, 0, 0));
    tbl.push_back(mk(0, 0, 2, 0, 0, 6'b000000, 0, 0));
    tbl.push_back(mk(1, 0, 2, 0, 0, 6'b000000, 0, 0));
    tbl.push_back(mk(1, 0, 2, 0, 1, 6'b111000, 0, 0));
    tbl.push_back(mk(1, 0, 2, 0, 2, 6'b000000, 0, 0));
    tbl.push_back(mk(1, 0, 6, 0, 3, 6'b100010, 0, 2));
    tbl.push_back(mk(1, 0, 1, 1, 1, 6'b111000, 0, 2));
    tbl.push_back(mk(1, 0, 1, 1, 2, 6'b001000, 0, 2));
    tbl.push_back(mk(1, 0, 1, 0, 1, 6'b111000, 0, 1));
    tbl.push_back(mk(1, 0, 1, 0, 2, 6'b000000, 0, 1));
    tbl.push_back(mk(1, 0, 7, 0, 1, 6'b111000, 0, 1));
    tbl.push_back(mk(1, 0, 7, 1, 2, 6'b000100, 0, 1));
    tbl.push_back(mk(1, 0, 6, 0, 1, 6'b111000, 0, 7));
    tbl.push_back(mk(1, 0, 6, 0, 2, 6'b000000, 0, 7));
    tbl.push_back(mk(1, 0, 2, 0, 3, 6'b000001, 0, 6));
    tbl.push_back(mk(1, 0, 0, 0, 1, 6'b111000, 0, 6));
    tbl.push_back(mk(1, 0, 0, 0, 2, 6'b000000, 0, 6));
    tbl.push_back(mk(1, 0, 3, 0, 4, 6'b000000, 1, 0));
    tbl.push_back(mk(1, 0, 3, 0, 4, 6'b000000, 1, 0));
    tbl.push_back(mk(1, 1, 3, 0, 4, 6'b000000, 1, 0));
    tbl.push_back(mk(1, 0, 3, 0, 0, 6'b000000, 0, 0));
    tbl.push_back(mk(1, 0, 3, 0, 1, 6'b111000, 0, 0));
    tbl.push_back(mk(1, 1, 3, 0, 2, 6'b000000, 0, 0));
    tbl.push_back(mk(1, 0, 3, 0, 0, 6'b000000, 0, 0));
    tbl.push_back(mk(1, 0, 3, 0, 1, 6'b111000, 0, 0));
    tbl.push_back(mk(1, 0, 3, 0, 2, 6'b000000, 0, 0));
    tbl.push_back(mk(1, 1, 3, 0, 3, 6'b000000, 0, 3));
    tbl.push_back(mk(1, 0, 3, 0, 0, 6'b000000, 0, 3));
    tbl.push_back(mk(1, 0, 3, 0, 1, 6'b111000, 0, 3));
    tbl.push_back(mk(1, 0, 3, 0, 2, 6'b000000, 0, 3));
    tbl.push_back(mk(0, 0, 3, 0, 3, 6'b100010, 0, 3));
    tbl.push_back(mk(1, 0, 3, 0, 0, 6'b000000, 0, 0));
    tbl.push_back(mk(1, 0, 3, 0, 1, 6'b111000, 0, 0));

    rst_a = 0; ld_a = 0; op_a = 3'd2; z_a = 0;
    rst_b = 0; ld_b = 0; op_b = 4'd0; z_b = 0;
    @(posedge clock);
    #1;

    foreach (tbl[i]) begin
      rst_a = tbl[i].rst; ld_a = tbl[i].ld;
      op_a = tbl[i].op; z_a = tbl[i].z;
      @(negedge clock);
      chk($sformatf("row%0d state", i), 32'(st_a), 32'(tbl[i].st));
      chk($sformatf("row%0d strobes", i),
          32'({mr_a, irl_a, pci_a, pcl_a, ea_a, em_a}),
          32'(tbl[i].stb));
      chk($sformatf("row%0d illegal_op", i), 32'(ill_a),
          32'(tbl[i].ill));
      chk($sformatf("row%0d halted", i), 32'(hlt_a), 32'(tbl[i].hlt));
      chk($sformatf("row%0d En_run", i), 32'(run_a),
          32'(tbl[i].st inside {[3'd1:3'd3]}));
      chk($sformatf("row%0d ALU_OP", i), 32'(alu_a), 32'(tbl[i].alu));
      @(posedge clock);
      #1;
    end
`ifdef CTRL_PERF_CNT_EN
    chk("A retired after reset", ret_a, 32'd0);
`endif
    rst_a = 0;

    m_alu = 4'd0;
    m_ret = 0;
    cyc_b(1'b0, 4'd0, 1'b0, 3'd0, 6'b0, 1'b0, "B reset");
    rst_b = 1;
    cyc_b(1'b0, 4'd0, 1'b0, 3'd0, 6'b0, 1'b0, "B idle");

    run_instr(4'b0110, 1'b0, -1, 0);
    run_instr(4'b0010, 1'b1, -1, 0);
    run_instr(4'b1010, 1'b0, -1, 0);
    run_instr(4'b0001, 1'b1, -1, 0);
    run_instr(4'b0001, 1'b0, -1, 0);
    run_instr(4'b0111, 1'b1, -1, 0);
    run_instr(4'b0000, 1'b0, -1, 20);
    run_instr(4'b0011, 1'b0, MW + 3, 0);
    run_instr(4'b0110, 1'b0, MW + 2 + MW, 0);
    run_instr(4'b0101, 1'b0, 1, 0);

    for (int n = 0; n < 250; n++) begin
      int ab;
      if ($urandom_range(0, 3) == 0)
        op = 4'($urandom);
      else
        op = {1'b0, 3'($urandom)};
      ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 9)) : -1;
      run_instr(op, 1'($urandom), ab, int'($urandom_range(0, 4)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_controller_mc.md
Name: cpu_controller_mc

Overview:
Multi-cycle instruction-sequencing controller for the 8-bit RISC CPU. It replaces the single-step enable logic with a FETCH/DECODE/EXEC state machine. The FSM drives the PC, IR, memory and accumulator strobes, supports programmable memory wait states and a generalised opcode width, and implements HALT, SKZ, JMP and illegal-opcode handling. It sits between the instruction register/accumulator datapath and the program/data memory.

Parameters:
OPCODE_W, 3, opcode width in bits; legal range 3..6. The low 3 bits select the instruction class. Any nonzero upper bit makes the opcode illegal.
MEM_WAIT, 0, number of extra wait cycles per memory read or write access; legal range 0..15.
WAIT_W, 4, width of the wait counter; must satisfy 2^WAIT_W > MEM_WAIT.

Ports:
clock  in  1  system clock; rising edge.
reset_n  in  1  synchronous, active-low reset.
Load_in  in  1  program-load mode; holds the CPU off the bus.
Opcode  in  OPCODE_W  current IR opcode field.
Zero  in  1  accumulator-zero flag.
mem_rd  out  1  memory read strobe.
ir_load  out  1  IR capture strobe.
pc_inc  out  1  PC increment strobe.
pc_load  out  1  PC load strobe (jump target).
En_acc  out  1  accumulator write enable.
En_mem  out  1  data memory write enable.
En_run  out  1  high while in FETCH, DECODE or EXEC.
ALU_OP  out  OPCODE_W  registered opcode presented to the ALU.
halted  out  1  high in HALT.
illegal_op  out  1  one-cycle pulse in DECODE when the opcode is illegal.
state  out  3  FSM state code: IDLE=0, FETCH=1, DECODE=2, EXEC=3, HALT=4.

Behaviour:
- Clock/reset: single clock. Reset is synchronous, active-low on reset_n; it is sampled only at the rising edge of clock.
- Reset values: state=IDLE, wait counter=0, ALU_OP=0. All strobes, halted and illegal_op are 0.
- Output timing: all strobes are decoded combinationally from (state, wait counter, Opcode, Zero). Every strobe is ANDed with ~Load_in.
- Load_in priority: Load_in=1 in any state → next state IDLE and counter cleared. Load_in has higher priority than every other transition except reset.
- IDLE: all strobes 0. If Load_in=0, go to FETCH.
- FETCH:
  - mem_rd=1 on every cycle in this state; the counter increments each cycle.
  - On the cycle where counter==MEM_WAIT: ir_load=1 and pc_inc=1, counter cleared, go to DECODE.
- DECODE: ALU_OP<=Opcode. The next state depends on the opcode class (low 3 bits, upper bits zero):
  - 000 HALT: go to HALT.
  - 001 SKZ: pc_inc=Zero; go to FETCH.
  - 010..101 ALU ops: go to EXEC.
  - 110 STO: go to EXEC.
  - 111 JMP: pc_load=1; go to FETCH.
  - Illegal opcode: illegal_op=1, no other strobe; go to FETCH (treated as a NOP).
- EXEC: the counter runs as in FETCH.
  - ALU class: mem_rd=1 on every cycle; En_acc=1 only on the cycle where counter==MEM_WAIT.
  - STO: En_mem=1 only on the cycle where counter==MEM_WAIT; mem_rd=0 throughout.
  - On the cycle where counter==MEM_WAIT: counter cleared, go to FETCH.
  - EXEC uses the registered ALU_OP, not the live Opcode, so IR changes during EXEC are ignored.
- HALT: halted=1, all strobes 0. Stay in HALT until Load_in=1, then go to IDLE.
- Instruction latency:
  - ALU or STO instruction: 2·(MEM_WAIT+1)+1 cycles.
  - SKZ, JMP or illegal: MEM_WAIT+2 cycles.
  - With MEM_WAIT=0: 3 cycles and 2 cycles respectively.
- Mutual exclusion: pc_inc and pc_load are never high in the same cycle. En_acc and En_mem are never high in the same cycle.
- Counter behaviour: the counter never exceeds MEM_WAIT. It is cleared on every state change.
- Reset mid-access: all strobes drop on the first clock edge with reset_n=0. No partial write is ever completed.

Optional Feature:
CTRL_PERF_CNT_EN:
- Defined: adds output port retired (32 bits). It resets to 0 and increments by 1 on every cycle that leaves DECODE via SKZ, JMP or illegal, or leaves EXEC. It wraps from 0xFFFFFFFF to 0. It holds during Load_in and HALT.
- Undefined: no retired port and no counter logic.

Test Plan:
1. MEM_WAIT=0: reset_n=0 for 2 cycles, then 1, with Load_in=0 and Opcode=3'b010 → state sequence 0,1,2,3,1. En_acc=1 on the 4th cycle after reset release. ALU_OP=3'b010.
2. MEM_WAIT=2, Opcode=3'b110 (STO) → mem_rd high for 3 cycles in FETCH. En_mem high exactly 1 cycle, 3 cycles into EXEC. Instruction takes 7 cycles.
3. SKZ with Zero=1 → two pc_inc pulses in this instruction (FETCH and DECODE). Repeat with Zero=0 → one pc_inc pulse. JMP → pc_load=1 in DECODE and pc_inc=0 in that cycle.
4. Opcode=3'b000 → halted=1 and held for 20 cycles with no strobes. Pulse Load_in=1 → state=IDLE on the next cycle. After Load_in drops, FETCH resumes.
5. OPCODE_W=4, Opcode=4'b1010 → illegal_op pulses for 1 cycle, En_acc never asserts, returns to FETCH.
6. Assert Load_in during EXEC of an ALU op with MEM_WAIT=3, before counter reaches MEM_WAIT → En_acc stays 0 and state=IDLE on the next cycle. With CTRL_PERF_CNT_EN defined, retired is not incremented.
